// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared constants and types for the fetch PC sequencer.
//   PC_RESET_DEFAULT : fetch address loaded on reset
//   INST_W           : instruction word width
//   seq_state_e      : sequencer state encoding (IDLE / REQ / WAIT)
//   pc_next_seq()    : sequential next fetch address (wraps modulo 2^32)
package pc_sequencer_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } seq_state_e;

  function automatic logic [31:0] pc_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory request/response channel.
//   imem_req_valid  : fetch request valid          (master -> slave)
//   imem_req_addr   : fetch address                (master -> slave)
//   imem_req_ready  : memory accepts this cycle    (slave -> master)
//   imem_resp_valid : response valid, one per accepted request (slave -> master)
//   imem_resp_data  : fetched instruction word     (slave -> master)
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic              imem_req_valid;
  logic [31:0]       imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// pc_reg: 32-bit program counter register.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset, loads RESET_PC
//   load_en : load pc_d this cycle
//   pc_d    : next PC value
//   pc_q    : current PC
module pc_reg
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [31:0] pc_d,
  output logic [31:0] pc_q
);

  always_ff @(posedge clk) begin
    if (reset)        pc_q <= RESET_PC;
    else if (load_en) pc_q <= pc_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer with a single-entry output buffer
// and at most one outstanding memory request.
//   clk, reset     : clock, synchronous active-high reset
//   stall          : decode cannot take the held instruction this cycle
//   redirect_valid : taken branch/jump, redirect_pc is the new fetch address
//   imem           : pc_sequencer_if.master fetch request/response channel
//   inst_valid     : inst_out / inst_pc hold a live instruction
//   inst_out       : held instruction word
//   inst_pc        : address of the held instruction
//   misalign_err   : sticky flag, redirect target was not word aligned
// Optional feature: define PC_SEQ_ALIGN_CHECK_EN to check redirect alignment
// (force target to a word boundary and raise misalign_err). Without it,
// misalign_err is 0 and redirect_pc is used unmodified.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  pc_sequencer_if.master    imem,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [31:0]       inst_pc,
  output logic              misalign_err
);

  seq_state_e        state_q, state_d;
  logic              kill_q, kill_d;
  logic [31:0]       inflight_q, inflight_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_out_q, inst_out_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       pc_q, pc_d;
  logic              pc_load;

  logic              consume, req_valid, req_fire;
  logic              redir_misaligned;
  logic [31:0]       redir_target;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (pc_load),
    .pc_d    (pc_d),
    .pc_q    (pc_q)
  );

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
  assign redir_target     = {redirect_pc[31:2], 2'b00};
`else
  assign redir_misaligned = 1'b0;
  assign redir_target     = redirect_pc;
`endif

  assign consume   = inst_valid_q && !stall;
  // Only fetch when the buffer will have room by the time the response lands.
  assign req_valid = (state_q == ST_REQ) && (!inst_valid_q || !stall);
  assign req_fire  = req_valid && imem.imem_req_ready;

  // pc only moves on a response or a redirect, so the address holds while
  // a request waits for ready.
  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc_q;

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    inflight_d   = inflight_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    misalign_d   = misalign_q;
    pc_d         = pc_q;
    pc_load      = 1'b0;

    if (consume) inst_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (req_fire) begin
          state_d    = ST_WAIT;
          inflight_d = pc_q;
          // Request leaves with the old address; its response must be dropped.
          kill_d     = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (imem.imem_resp_valid) begin
          state_d = ST_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_valid) begin
            inst_valid_d = 1'b1;
            inst_out_d   = imem.imem_resp_data;
            inst_pc_d    = inflight_q;
            pc_d         = pc_next_seq(pc_q);
            pc_load      = 1'b1;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect overrides sequential advance and flushes the buffer.
    if (redirect_valid) begin
      pc_d         = redir_target;
      pc_load      = 1'b1;
      inst_valid_d = 1'b0;
      if (redir_misaligned) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      kill_q       <= 1'b0;
      inflight_q   <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      inflight_q   <= inflight_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst_out     = inst_out_q;
  assign inst_pc      = inst_pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// transaction-level model (fetch address stream, kill window, output buffer).
// Honours PC_SEQ_ALIGN_CHECK_EN the same way as the design.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, misalign_err;
  logic [31:0] inst_out, inst_pc;

  pc_sequencer_if imem();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int d_delay = 1;

  // reference model state
  logic [31:0] m_pc = RST_PC, m_out = 32'h0, m_ipc = 32'h0, m_fa = 32'h0;
  logic        m_iv = 1'b0, m_idle = 1'b1, m_os = 1'b0, m_killed = 1'b0, m_err = 1'b0;

  // memory responder
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  // last sampled DUT outputs
  logic        s_iv = 1'b0, s_rv = 1'b0, s_err = 1'b0;
  logic [31:0] s_out = 32'h0, s_ipc = 32'h0, s_addr = 32'h0;
  logic [31:0] hs_log[$];
  logic [31:0] inst_log[$];

  logic [31:0] held_out, held_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] tgt_of(input logic [31:0] p);
`ifdef PC_SEQ_ALIGN_CHECK_EN
    return {p[31:2], 2'b00};
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic exp_rv, hs_m, resp_m, hs_d, deliver, prev_iv;
    logic [31:0] tgt, prev_ipc;
    @(negedge clk);
    imem.imem_resp_valid = (mem_cnt == 1);
    imem.imem_resp_data  = (mem_cnt == 1) ? memf(mem_addr) : 32'h0;
    #1;
    prev_iv  = s_iv;
    prev_ipc = s_ipc;
    s_iv   = inst_valid;
    s_out  = inst_out;
    s_ipc  = inst_pc;
    s_err  = misalign_err;
    s_rv   = imem.imem_req_valid;
    s_addr = imem.imem_req_addr;
    exp_rv = !m_idle && !m_os && (!m_iv || !stall);
    chkb("req_valid", s_rv, exp_rv);
    if (exp_rv) chk("req_addr", s_addr, m_pc);
    chkb("inst_valid", s_iv, m_iv);
    if (m_iv) begin
      chk("inst_pc", s_ipc, m_ipc);
      chk("inst_out", s_out, m_out);
    end
    chkb("misalign_err", s_err, m_err);
    if (s_iv && (!prev_iv || s_ipc != prev_ipc)) inst_log.push_back(s_ipc);
    hs_d = s_rv && imem.imem_req_ready;
    if (hs_d) hs_log.push_back(s_addr);
    hs_m   = exp_rv && imem.imem_req_ready;
    resp_m = m_os && imem.imem_resp_valid;
    tgt    = tgt_of(redirect_pc);
    @(posedge clk);
    #1;
    if (reset) begin
      m_pc = RST_PC; m_iv = 1'b0; m_out = 32'h0; m_ipc = 32'h0;
      m_idle = 1'b1; m_os = 1'b0; m_killed = 1'b0; m_err = 1'b0;
    end else begin
      deliver = resp_m && !m_killed && !redirect_valid;
      if (resp_m) m_os = 1'b0;
      if (hs_m) begin
        m_os = 1'b1; m_killed = redirect_valid; m_fa = m_pc;
      end else if (m_os && redirect_valid) begin
        m_killed = 1'b1;
      end
      if (redirect_valid) begin
        m_iv = 1'b0; m_pc = tgt;
        if (tgt != redirect_pc) m_err = 1'b1;
      end else if (deliver) begin
        m_iv = 1'b1; m_out = memf(m_fa); m_ipc = m_fa; m_pc = m_fa + 32'd4;
      end else if (m_iv && !stall) begin
        m_iv = 1'b0;
      end
      m_idle = 1'b0;
    end
    if (mem_cnt > 0) mem_cnt--;
    if (hs_d) begin mem_cnt = d_delay; mem_addr = s_addr; end
  endtask

  task automatic wait_rv(input int maxc);
    int k = 0;
    do begin cycle(); k++; end while (!s_rv && k < maxc);
    chkb("wait_req_valid", s_rv, 1'b1);
  endtask

  task automatic wait_hs(input int maxc);
    int k = 0;
    do begin cycle(); k++; end while (!(s_rv && imem.imem_req_ready) && k < maxc);
    chkb("wait_handshake", s_rv, 1'b1);
  endtask

  task automatic wait_inst(input int maxc);
    int k = 0;
    do begin cycle(); k++; end while (!s_iv && k < maxc);
    chkb("wait_inst", s_iv, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    imem.imem_req_ready  = 1'b1;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = 32'h0;

    // reset state
    reset = 1'b1;
    cycle(); cycle();
    chkb("rst_inst_valid", s_iv, 1'b0);
    chk ("rst_inst_out", s_out, 32'h0);
    chk ("rst_inst_pc", s_ipc, 32'h0);
    chkb("rst_req_valid", s_rv, 1'b0);
    chkb("rst_misalign", s_err, 1'b0);

    // sequential fetch from the reset address
    reset = 1'b0;
    hs_log.delete(); inst_log.delete();
    repeat (8) cycle();
    chk("seq_addr0", hs_log[0], 32'h2000);
    chk("seq_addr1", hs_log[1], 32'h2004);
    chk("seq_addr2", hs_log[2], 32'h2008);
    chk("seq_ipc0", inst_log[0], 32'h2000);
    chk("seq_ipc1", inst_log[1], 32'h2004);
    chk("seq_ipc2", inst_log[2], 32'h2008);

    // stall holds the buffer and blocks new requests
    stall = 1'b1;
    wait_inst(10);
    chk("stall_pc", s_ipc, 32'h200C);
    held_out = s_out;
    repeat (3) begin
      cycle();
      chk ("stall_out", s_out, held_out);
      chkb("stall_no_req", s_rv, 1'b0);
    end
    stall = 1'b0;
    d_delay = 3;
    cycle();
    chkb("unstall_req", s_rv, 1'b1);
    chk ("unstall_addr", s_addr, 32'h2010);

    // redirect while waiting: late response dropped
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    cycle();
    redirect_valid = 1'b0;
    cycle(); chkb("kill_iv0", s_iv, 1'b0);
    cycle(); chkb("kill_iv1", s_iv, 1'b0);
    d_delay = 1;
    cycle();
    chkb("kill_iv2", s_iv, 1'b0);
    chkb("kill_req", s_rv, 1'b1);
    chk ("kill_addr", s_addr, 32'h3000);

    // redirect coincident with a live response
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chkb("coinc_iv", s_iv, 1'b0);
    chk ("coinc_addr", s_addr, 32'h4000);

    // backpressure: request and address held
    imem.imem_req_ready = 1'b0;
    wait_rv(10);
    chk("bp_addr0", s_addr, 32'h4004);
    repeat (5) begin
      cycle();
      chkb("bp_valid", s_rv, 1'b1);
      chk ("bp_addr", s_addr, 32'h4004);
    end

    // wrap at top of address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    hs_log.delete(); inst_log.delete();
    imem.imem_req_ready = 1'b1;
    repeat (6) cycle();
    chk("wrap_addr0", hs_log[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", hs_log[1], 32'h0000_0000);
    chk("wrap_ipc0", inst_log[0], 32'hFFFF_FFFC);

    // reset while a request is in flight
    d_delay = 2;
    wait_hs(10);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    d_delay = 1;
    cycle();
    chkb("rstw_iv", s_iv, 1'b0);
    chkb("rstw_idle", s_rv, 1'b0);
    cycle();
    chkb("rstw_req", s_rv, 1'b1);
    chk ("rstw_addr", s_addr, 32'h2000);

    // misaligned redirect
    imem.imem_req_ready = 1'b0;
    wait_rv(10);
    redirect_valid = 1'b1; redirect_pc = 32'h3002;
    cycle();
    redirect_valid = 1'b0;
    cycle();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    chkb("mis_err", s_err, 1'b1);
    chk ("mis_addr", s_addr, 32'h3000);
    cycle();
    chkb("mis_sticky", s_err, 1'b1);
`else
    chkb("mis_err", s_err, 1'b0);
    chk ("mis_addr", s_addr, 32'h3002);
`endif
    imem.imem_req_ready = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      stall               = ($urandom_range(0, 9) < 3);
      imem.imem_req_ready = ($urandom_range(0, 9) < 7);
      redirect_valid      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0;
      else                           redirect_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      d_delay = $urandom_range(1, 3);
      cycle();
    end
    stall = 1'b0; redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_2000: fetch address loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  decode cannot accept; a held instruction is not consumed this cycle.
REQ-005 redirect_valid  input  1  branch/jump taken; overrides sequential fetch.
REQ-006 redirect_pc  input  32  redirect target.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  32  fetch address.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_resp_valid  input  1  response data valid, one cycle per accepted request.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 inst_valid  output  1  inst_out/inst_pc hold a live instruction.
REQ-013 inst_out  output  32  held instruction.
REQ-014 inst_pc  output  32  address of held instruction.
REQ-015 misalign_err  output  1  redirect target not 4-byte aligned (see Configuration).

Function
REQ-016 States: IDLE, REQ, WAIT; one outstanding request maximum.
REQ-017 IDLE: imem_req_valid=0; always advance to REQ next cycle.
REQ-018 REQ: imem_req_valid=1 and imem_req_addr=pc only while the output buffer is empty, or is being consumed this cycle (inst_valid and !stall); otherwise imem_req_valid=0 and state holds.
REQ-019 REQ to WAIT on imem_req_valid && imem_req_ready; the fetch address is latched as the in-flight address.
REQ-020 WAIT with imem_resp_valid and no kill: inst_out<=imem_resp_data, inst_pc<=in-flight address, inst_valid<=1, pc<=pc+4, state<=REQ; response-to-inst_valid latency is one cycle.
REQ-021 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC to 32'h0000_0000).
REQ-022 inst_valid clears on a consume edge (inst_valid && !stall) unless a new response loads the buffer on that same edge.
REQ-023 redirect_valid has highest priority: pc<=redirect_pc and inst_valid<=0 on the same edge.
REQ-024 Redirect in WAIT, or in REQ coincident with a request handshake, sets kill; the next response is dropped, kill clears, and state returns to REQ with the redirected pc.
REQ-025 Redirect coincident with a non-killed response: redirect wins; the response is dropped and pc is not incremented.
REQ-026 imem_req_addr is stable while imem_req_valid=1 and !imem_req_ready, except on redirect.

Reset
REQ-027 reset (synchronous, priority over all inputs): pc=RESET_PC, state=IDLE, kill=0, inst_valid=0, inst_out=0, inst_pc=0, misalign_err=0, imem_req_valid=0.
REQ-028 Reset during WAIT abandons the in-flight request; the late response is ignored because state is IDLE.

Configuration
REQ-029 Macro PC_SEQ_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 sets sticky misalign_err (cleared only by reset) and redirects to {redirect_pc[31:2],2'b00}.
REQ-030 Macro not defined: misalign_err tied 0; redirect_pc used unmodified.

Structure
REQ-031 Shared package holds the PC reset constant, state encoding, and the instruction width constant.
REQ-032 One sub-module, pc_reg: 32-bit PC register with synchronous reset to RESET_PC and next-value load enable; all sequencing in pc_sequencer.

Verification
REQ-033 Reset release, ready=1, resp one cycle after accept -> addresses 0x2000, 0x2004, 0x2008; inst_pc matches each address.
REQ-034 stall=1 for 3 cycles with inst_valid=1 -> inst_out stable, no new imem_req_valid; after stall drops, next request addr=pc+4.
REQ-035 redirect_pc=0x3000 during WAIT -> response for the old address dropped, inst_valid stays 0, next request addr=0x3000.
REQ-036 imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and addr constant throughout.
REQ-037 pc=0xFFFF_FFFC fetch completes -> next request addr=0x0000_0000.
REQ-038 With PC_SEQ_ALIGN_CHECK_EN, redirect_pc=0x3002 -> misalign_err=1 (sticky), next request addr=0x3000.
